valid_stream_rx: RTL and testbench
==================================

# valid_stream_rx

Receive-side buffer and checker for the 32-bit valid/data stream produced by the `ex1_1` pipeline family. It captures every word presented with `validi` into a small FIFO and lets a downstream consumer drain that FIFO at its own pace. It flags overflow and, optionally, checks that received words follow an incrementing sequence. It sits directly after a `valido`/`data_out` producer, both in the lab testbench and in integrated designs.

## Interface
Parameters:
- `WIDTH`, default 32: data width.
- `DEPTH`, default 4: FIFO depth; must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `validi`  in  1  upstream word valid. There is no backpressure: the word is presented once only.
- `data_in`  in  WIDTH  upstream data, sampled when `validi`=1.
- `rd_en`  in  1  downstream read request.
- `valido`  out  1  one-cycle pulse: `data_out` holds a popped word.
- `data_out`  out  WIDTH  registered read data.
- `empty`  out  1  FIFO holds 0 words.
- `full`  out  1  FIFO holds `DEPTH` words.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `ovf`  out  1  sticky: a word was dropped.
- `word_cnt`  out  16  number of accepted words; wraps modulo 2^16.
- `seq_err`  out  1  sticky sequence error. Present only when the sequence checker is compiled in.
- `err_cnt`  out  8  saturating count of sequence mismatches. Present only when the sequence checker is compiled in.

## Operation
- **Reset** (`rst`=0, asynchronous): all outputs are driven to 0 and `empty`=1. Pointers and counters clear. The checker returns to its FIRST state.
- **Write:**
  - When `validi`=1, the word is accepted if `full`=0, or if `full`=1 and a read occurs in the same cycle.
  - Otherwise the word is dropped, `ovf` is set (sticky until reset), and `count` is unchanged.
  - Each accepted word increments `word_cnt`.
- **Read:**
  - When `rd_en`=1 and `empty`=0 at the clock edge, the head word is popped.
  - On that edge, `data_out` is loaded with the popped word and `valido`=1 for that cycle.
  - `rd_en` while `empty`=1 is ignored: `valido`=0 and `data_out` holds its previous value.
- **Simultaneous read and write:**
  - When not empty: both take effect and `count` is unchanged.
  - When empty: the write is accepted, the read is ignored, and there is no fall-through.
  - When full: both take effect, no drop occurs, and `ovf` is not set.
- **Pointers:** wrap modulo `DEPTH`. `count` is tracked explicitly; full and empty are derived from `count`.
- **Sequence checker** (two-state FSM):
  - FIRST: on the first `validi` word, store `exp = data_in + 1` and move to TRACK.
  - TRACK: for each `validi` word, if `data_in != exp`:
    - set `seq_err`;
    - increment `err_cnt`, saturating at 255.
  - In both cases, then set `exp = data_in + 1`, which resynchronises the checker.
  - Arithmetic is modulo 2^WIDTH, so `0xFFFFFFFF` followed by `0` is legal.
  - The checker sees every `validi` word, including dropped ones.

## Timing
- Write-to-readable latency is 1 cycle: a word written at edge N makes `empty`=0 after edge N, so it can be popped at edge N+1.
- Read latency is 1 cycle: `rd_en` sampled at edge N gives `data_out`/`valido` valid after edge N.
- `count`, `full`, `empty`, `ovf`, `word_cnt`, `seq_err`, and `err_cnt` all update on the same edge as the event that changes them.
- Sustained throughput is 1 word per cycle in and out.
- Reset asserted mid-stream discards all buffered data immediately. No `valido` pulse occurs while `rst`=0 or on the first edge after release.

## Configuration
- `VALID_STREAM_RX_SEQCHK_EN` defined: the sequence checker FSM, `seq_err`, and `err_cnt` are built.
- Macro undefined:
  - the checker logic is removed;
  - `seq_err` and `err_cnt` are tied to 0 but remain in the port list so instantiations do not change.
  - FIFO behaviour is identical in both builds.

## Test plan
- **Reset values:** hold `rst`=0 for 2 cycles → `empty`=1, `full`=0, `count`=0, `valido`=0, `ovf`=0, `word_cnt`=0, `err_cnt`=0.
- **Basic write then read:**
  - Stimulus: write 1,2,3,4 on consecutive cycles with `rd_en`=0.
  - Required: `full`=1 and `count`=4.
  - Then 4 reads → `data_out` 1,2,3,4 with 4 `valido` pulses, then `empty`=1.
- **Overflow with full-and-read:**
  - Stimulus: while full, write 5 with `rd_en`=0.
  - Required: 5 is dropped and `ovf`=1.
  - Next, write 6 together with `rd_en`=1 → 6 is accepted, `count` stays 4, `word_cnt`=5.
- **Empty boundary:**
  - `validi` and `rd_en` both asserted while empty → `valido`=0, `count`=1.
  - `rd_en` while empty → no `valido` pulse and `data_out` unchanged.
- **Sequence check:**
  - Stimulus: `validi` words 3,5,6,9,10,11,13 (the lab stimulus pattern).
  - Required: `seq_err`=1 and `err_cnt`=3, from mismatches at 5, 9, and 13.
  - Stimulus: `0xFFFFFFFE`, `0xFFFFFFFF`, `0` → no error.
  - With the macro undefined, both outputs read 0.
- **Reset mid-operation:** with `count`=3, pulse `rst`=0 between edges → `count`=0 immediately. After release, a write of 7 followed by a read returns 7.

Source files
------------

// File: rtl/valid_stream_rx.sv
// valid_stream_rx: receive FIFO with overflow flag and optional incrementing-sequence checker (rev 1.0).
// Define VALID_STREAM_RX_SEQCHK_EN to build the checker; otherwise seq_err/err_cnt are tied to 0.
`default_nettype none

module valid_stream_rx #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     validi,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic                     valido,
  output logic [WIDTH-1:0]         data_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic [15:0]              word_cnt,
  output logic                     seq_err,
  output logic [7:0]               err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             valido_q, ovf_q;
  logic [WIDTH-1:0] data_q;
  logic [15:0]      word_cnt_q;
  logic             rd_ok, wr_ok, is_full, is_empty;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign rd_ok    = rd_en && !is_empty;
  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign wr_ok    = validi && (!is_full || rd_ok);

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valido_q   <= 1'b0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      count_q  <= count_d;
      valido_q <= rd_ok;
      if (rd_ok) begin
        data_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (wr_ok) begin
        wr_ptr_q   <= wr_ptr_q + AW'(1);
        word_cnt_q <= word_cnt_q + 16'd1;
      end else if (validi) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

  assign valido   = valido_q;
  assign data_out = data_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign word_cnt = word_cnt_q;

`ifdef VALID_STREAM_RX_SEQCHK_EN
  typedef enum logic {ST_FIRST = 1'b0, ST_TRACK = 1'b1} chk_state_e;

  chk_state_e       state_q;
  logic [WIDTH-1:0] exp_q;
  logic             seq_err_q;
  logic [7:0]       err_cnt_q;

  // Every presented word is checked, dropped or not; a mismatch resyncs to it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FIRST;
      exp_q     <= '0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (validi) begin
      exp_q <= data_in + WIDTH'(1);
      case (state_q)
        ST_FIRST: state_q <= ST_TRACK;
        ST_TRACK: begin
          if (data_in != exp_q) begin
            seq_err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_FIRST;
      endcase
    end
  end

  assign seq_err = seq_err_q;
  assign err_cnt = err_cnt_q;
`else
  assign seq_err = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_valid_stream_rx.sv
// tb_valid_stream_rx: scoreboard bench for valid_stream_rx (WIDTH=32, DEPTH=4).
`default_nettype none

module tb_valid_stream_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        validi = 1'b0;
  logic [31:0] data_in = '0;
  logic        rd_en = 1'b0;
  logic        valido;
  logic [31:0] data_out;
  logic        empty, full, ovf, seq_err;
  logic [2:0]  count;
  logic [15:0] word_cnt;
  logic [7:0]  err_cnt;

  valid_stream_rx #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .validi(validi), .data_in(data_in), .rd_en(rd_en),
    .valido(valido), .data_out(data_out), .empty(empty), .full(full),
    .count(count), .ovf(ovf), .word_cnt(word_cnt), .seq_err(seq_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb [$];
  logic [31:0] m_dout;
  logic        m_ovf;
  logic [15:0] m_wc;
  logic        m_first, m_serr;
  logic [31:0] m_exp;
  logic [7:0]  m_ecnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_dout = '0; m_ovf = 1'b0; m_wc = '0;
    m_first = 1'b1; m_serr = 1'b0; m_exp = '0; m_ecnt = '0;
  endtask

  function automatic logic exp_serr();
`ifdef VALID_STREAM_RX_SEQCHK_EN
    return m_serr;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_ecnt();
`ifdef VALID_STREAM_RX_SEQCHK_EN
    return m_ecnt;
`else
    return 8'd0;
`endif
  endfunction

  task automatic check_state();
    chk("count", count, sb.size());
    chk("empty", empty, sb.size() == 0);
    chk("full", full, sb.size() == 4);
    chk("ovf", ovf, m_ovf);
    chk("word_cnt", word_cnt, m_wc);
    chk("seq_err", seq_err, exp_serr());
    chk("err_cnt", err_cnt, exp_ecnt());
  endtask

  // One clock: drive inputs, advance the model, compare everything.
  task automatic step(input logic v, input logic [31:0] d, input logic r);
    logic rd_ok, wr_ok;
    validi = v; data_in = d; rd_en = r;
    rd_ok = r && (sb.size() > 0);
    wr_ok = v && ((sb.size() < 4) || rd_ok);
    @(posedge clk); #1;
    chk("valido", valido, rd_ok);
    if (rd_ok) m_dout = sb.pop_front();
    chk("data_out", data_out, m_dout);
    if (wr_ok) begin
      sb.push_back(d);
      m_wc = m_wc + 16'd1;
    end else if (v) begin
      m_ovf = 1'b1;
    end
    if (v) begin
      if (!m_first && d != m_exp) begin
        m_serr = 1'b1;
        if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
      end
      m_first = 1'b0;
      m_exp = d + 32'd1;
    end
    check_state();
    validi = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; validi = 1'b0; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_valido", valido, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_word_cnt", word_cnt, 16'd0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [31:0] seq_a [7] = '{32'd3, 32'd5, 32'd6, 32'd9, 32'd10, 32'd11, 32'd13};
  logic [31:0] seq_b [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};

  initial begin
    model_clear();
    do_reset();

    // Fill, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0);
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, 3'd4);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 32'd0, 1'b1);
      chk("drain_data", data_out, 32'(i));
    end
    chk("drain_empty", empty, 1'b1);

    // Overflow, then write-while-full with a read.
    for (int i = 5; i <= 8; i++) step(1'b1, 32'(i), 1'b0);
    step(1'b1, 32'd9, 1'b0);
    chk("drop_ovf", ovf, 1'b1);
    chk("drop_count", count, 3'd4);
    step(1'b1, 32'd10, 1'b1);
    chk("fullrw_count", count, 3'd4);
    chk("fullrw_word_cnt", word_cnt, 16'd9);
    chk("fullrw_data", data_out, 32'd5);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);
    chk("drain2_last", data_out, 32'd10);

    // Empty boundary: no fall-through, reads on empty ignored.
    step(1'b1, 32'd11, 1'b1);
    chk("empty_rw_valido", valido, 1'b0);
    chk("empty_rw_count", count, 3'd1);
    step(1'b0, 32'd0, 1'b1);
    chk("pop11", data_out, 32'd11);
    step(1'b0, 32'd0, 1'b1);
    chk("empty_rd_valido", valido, 1'b0);
    chk("empty_rd_hold", data_out, 32'd11);

    // Sequence checker: lab pattern then wrap-around.
    do_reset();
    foreach (seq_a[i]) step(1'b1, seq_a[i], 1'b1);
    step(1'b0, 32'd0, 1'b1);
`ifdef VALID_STREAM_RX_SEQCHK_EN
    chk("seq_a_err", seq_err, 1'b1);
    chk("seq_a_cnt", err_cnt, 8'd3);
`else
    chk("seq_a_err", seq_err, 1'b0);
    chk("seq_a_cnt", err_cnt, 8'd0);
`endif
    do_reset();
    foreach (seq_b[i]) step(1'b1, seq_b[i], 1'b1);
    step(1'b0, 32'd0, 1'b1);
    chk("seq_b_err", seq_err, 1'b0);
    chk("seq_b_cnt", err_cnt, 8'd0);
    chk("seq_b_last", data_out, 32'd0);

    // Asynchronous reset mid-stream.
    step(1'b1, 32'd20, 1'b0);
    step(1'b1, 32'd21, 1'b0);
    step(1'b1, 32'd22, 1'b0);
    chk("pre_rst_count", count, 3'd3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", count, 3'd0);
    chk("async_rst_empty", empty, 1'b1);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 32'd0, 1'b1);
    chk("post_rst_valido", valido, 1'b0);
    step(1'b1, 32'd7, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    chk("post_rst_data", data_out, 32'd7);
    chk("post_rst_pulse", valido, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
